bcd_counter_scan: RTL and testbench
===================================

// Module: bcd_counter_scan
// PURPOSE
//   Multi-digit BCD up/down counter with parallel load, enable and terminal-count pulse.
//   Includes an integrated time-multiplexed 7-segment scan driver.
//   Successor to the single-digit BCD counter/decoder: N decades, direction control,
//   optional leading-zero blanking and a common-anode display scan.
//   Sits between board control logic (buttons/timers) and the display pins.
// PARAMETERS
//   DIGITS    4    number of BCD decades; legal range 1..8
//   SCAN_DIV  1000 clk cycles each digit stays lit; must be >= 2
//   BLANK_LZ  0    1 = blank leading zero digits; digit 0 is never blanked
// PORTS
//   clk    in   1          rising-edge clock
//   rst    in   1          asynchronous reset, active-high
//   en     in   1          count enable; one step per clk while high
//   up_dn  in   1          1 = count up, 0 = count down
//   load   in   1          synchronous parallel load
//   din    in   4*DIGITS   load value; digit k is din[4k+3:4k], digit 0 is the LSD
//   q      out  4*DIGITS   current BCD count, same packing as din
//   tc     out  1          terminal-count pulse, one cycle wide
//   seg    out  8          active-low segments {dp,g,f,e,d,c,b,a}
//   an     out  DIGITS     active-low digit select; exactly one bit is low while scanning
// BEHAVIOUR
//   Reset: asynchronous, active-high, applies regardless of clk.
//     q=0, tc=0, scan index=0, prescaler=0, seg=8'hFF, an=all ones.
//   Counter (registered), priority load > en > hold:
//     load=1: each digit <= din digit; digit values 10..15 are clamped to 9.
//       tc=0 on a load cycle.
//     en=1, up_dn=1: LSD +1; a digit at 9 wraps to 0 and carries into the next digit.
//     en=1, up_dn=0: LSD -1; a digit at 0 wraps to 9 and borrows from the next digit.
//     Full wrap: all-9s -> all-0s (up) and all-0s -> all-9s (down).
//       tc is registered high in the same cycle q takes the wrapped value; low otherwise.
//     up_dn may change on any cycle; it takes effect on the next enabled edge.
//   Scan:
//     The prescaler counts 0..SCAN_DIV-1 continuously and is independent of en and load.
//     At prescaler == SCAN_DIV-1 the scan index advances, wrapping DIGITS-1 -> 0.
//     seg and an are registered every cycle from the scan index and q.
//       One-cycle latency; both update on the same edge, so there are no ghosting glitches.
//     an = ~(1 << idx). The first post-reset edge drives an[0]=0.
//   Decode (dp always 1):
//     0=C0  1=F9  2=A4  3=B0  4=99  5=92  6=82  7=F8  8=80  9=90
//     Blanked digit = FF.
//   Leading-zero blank (BLANK_LZ=1):
//     Digit k is blanked iff it and every digit above it are 0, for k >= 1.
//   Reset mid-count or mid-scan: immediate return to the reset values.
//     The scan restarts at digit 0.
// STRUCTURE
//   bcd_pkg holds:
//     localparam SEG_BLANK = 8'hFF;
//     function seg7_dec(input [3:0]) returning the table above; values 10..15 decode to SEG_BLANK.
//   Sub-module bcd_digit: one decade cell.
//     Inputs: ld, d, step_in, up_dn. Outputs: q[3:0], step_out.
//     step_out = step_in & (up ? q==9 : q==0).
//   Top level:
//     generate loop of DIGITS bcd_digit cells chained step_out -> step_in.
//     tc logic from the final step_out.
//     Prescaler, scan index, LZ mask, output registers.
// TESTING
//   Bench parameters: DIGITS=4, SCAN_DIV=4.
//   1. Load 9998, en=1, up_dn=1 -> q=9999, then 0000 with tc=1 for exactly that one cycle, then 0001.
//   2. Load 0001, en=1, up_dn=0 -> q=0000, then 9999 with tc=1, then 9998; BCD digits never leave 0..9.
//   3. load=1, en=1 in the same cycle, din=16'h12F4 -> q=16'h1294; tc=0; count resumes from 1294 on the next cycle.
//   4. Hold q=1234, en=0 -> an cycles E,D,B,7 every 4 clocks with seg 99,B0,A4,F9 respectively, aligned on the same edges.
//   5. BLANK_LZ=1, q=0007 -> seg FF,FF,FF on an=B,D,7 and F8 on an=E; q=0000 shows C0 on digit 0 only.
//   6. Assert rst between clock edges mid-scan with q=0456 -> q=0, tc=0, seg=FF, an=F before the next edge; on release the scan restarts at an=E.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and helpers for the BCD counter and its display scan.
//   SEG_BLANK  active-low segment pattern with every segment dark
//   bcd_clamp  saturates a nibble to a legal BCD digit (10..15 -> 9)
//   seg7_dec   BCD digit to active-low {dp,g,f,e,d,c,b,a}; 10..15 decode blank
package bcd_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    function automatic logic [7:0] seg7_dec(input logic [3:0] v);
        case (v)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade of the BCD up/down counter.
//   clk, rst   clock and asynchronous active-high reset
//   ld, d      parallel load (wins over stepping), value clamped to 0..9
//   step_in    step this digit by one in the direction of up_dn
//   up_dn      1 = up, 0 = down
//   q          current digit value
//   step_out   carry/borrow into the next decade
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [3:0] d,
    input  logic       step_in,
    input  logic       up_dn,
    output logic [3:0] q,
    output logic       step_out
);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            q <= '0;
        else if (ld)
            q <= bcd_clamp(d);
        else if (step_in)
            q <= up_dn ? ((q == 4'd9) ? 4'd0 : q + 4'd1)
                       : ((q == 4'd0) ? 4'd9 : q - 4'd1);

    assign step_out = step_in & (up_dn ? (q == 4'd9) : (q == 4'd0));

endmodule

// File: rtl/bcd_counter_scan.sv
// bcd_counter_scan: N-decade BCD up/down counter with load, enable and
// terminal-count pulse, plus a time-multiplexed common-anode 7-segment scan.
//   clk, rst  clock and asynchronous active-high reset
//   en        count enable, up_dn direction (1 = up)
//   load, din synchronous parallel load, digit k in din[4k+3:4k]
//   q         current count, same packing as din
//   tc        one-cycle pulse on the full wrap (all-9s <-> all-0s)
//   seg, an   active-low segments and digit select, registered together
module bcd_counter_scan
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_LZ = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up_dn,
    input  logic                load,
    input  logic [4*DIGITS-1:0] din,
    output logic [4*DIGITS-1:0] q,
    output logic                tc,
    output logic [7:0]          seg,
    output logic [DIGITS-1:0]   an
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIGITS:0]   step;
    logic [PW-1:0]     pre;
    logic [IW-1:0]     idx;
    logic [3:0]        cur;
    logic [DIGITS-1:0] blank;
    logic              zero_above;

    // The carry chain enters at the LSD; load overrides stepping inside each cell.
    assign step[0] = en;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit u_dig (
            .clk      (clk),
            .rst      (rst),
            .ld       (load),
            .d        (din[4*g +: 4]),
            .step_in  (step[g]),
            .up_dn    (up_dn),
            .q        (q[4*g +: 4]),
            .step_out (step[g+1])
        );
    end

    // A step out of the top decade is exactly the full wrap.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            tc <= 1'b0;
        else
            tc <= ~load & step[DIGITS];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else begin
            pre <= (pre == PW'(SCAN_DIV - 1)) ? '0 : pre + PW'(1);
            if (pre == PW'(SCAN_DIV - 1))
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end

    // Walk from the MSD down so each digit knows whether everything above is zero.
    always_comb begin
        cur        = '0;
        blank      = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (q[4*k +: 4] == 4'd0);
            blank[k]   = (BLANK_LZ != 0) && (k != 0) && zero_above;
            if (idx == IW'(k))
                cur = q[4*k +: 4];
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= blank[idx] ? SEG_BLANK : seg7_dec(cur);
            an  <= ~(DIGITS'(1) << idx);
        end

endmodule

// File: tb/tb_bcd_counter_scan.sv
// tb_bcd_counter_scan: directed self-checking bench for bcd_counter_scan
// (DIGITS=4, SCAN_DIV=4), with a second instance that blanks leading zeros.
module tb_bcd_counter_scan;

    logic        clk = 1'b0;
    logic        rst, en, up_dn, load;
    logic [15:0] din;
    logic [15:0] q, q_lz;
    logic        tc, tc_lz;
    logic [7:0]  seg, seg_lz;
    logic [3:0]  an, an_lz;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] an_t  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] seg_t [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] lz_t  [4] = '{8'hF8, 8'hFF, 8'hFF, 8'hFF};

    bcd_counter_scan #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(0)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .din(din),
        .q(q), .tc(tc), .seg(seg), .an(an)
    );

    bcd_counter_scan #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1)) dut_lz (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .din(din),
        .q(q_lz), .tc(tc_lz), .seg(seg_lz), .an(an_lz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; din = '0;
        #2;
        check("rst_q",   q, 16'h0000);
        check("rst_tc",  16'(tc), 16'h0);
        check("rst_seg", 16'(seg), 16'h00FF);
        check("rst_an",  16'(an), 16'h000F);
        check("rst_lz_seg", 16'(seg_lz), 16'h00FF);
        #6 rst = 1'b0;

        // up through the full wrap
        load = 1'b1; din = 16'h9998; en = 1'b1; up_dn = 1'b1;
        step();
        check("up_load_q", q, 16'h9998);
        check("up_load_tc", 16'(tc), 16'h0);
        load = 1'b0;
        step(); check("up_q1", q, 16'h9999); check("up_tc1", 16'(tc), 16'h0);
        step(); check("up_q2", q, 16'h0000); check("up_tc2", 16'(tc), 16'h1);
        step(); check("up_q3", q, 16'h0001); check("up_tc3", 16'(tc), 16'h0);

        // down through the full wrap
        load = 1'b1; din = 16'h0001; up_dn = 1'b0;
        step(); check("dn_load_q", q, 16'h0001);
        load = 1'b0;
        step(); check("dn_q1", q, 16'h0000); check("dn_tc1", 16'(tc), 16'h0);
        step(); check("dn_q2", q, 16'h9999); check("dn_tc2", 16'(tc), 16'h1);
        step(); check("dn_q3", q, 16'h9998); check("dn_tc3", 16'(tc), 16'h0);

        // load beats enable, with clamping
        load = 1'b1; din = 16'h12F4; up_dn = 1'b1;
        step(); check("ld_clamp_q", q, 16'h1294); check("ld_clamp_tc", 16'(tc), 16'h0);
        load = 1'b0;
        step(); check("ld_resume_q", q, 16'h1295);

        // all-F load clamps to 9999, then wraps
        load = 1'b1; din = 16'hFFFF;
        step(); check("ld_ffff_q", q, 16'h9999); check("ld_ffff_tc", 16'(tc), 16'h0);
        load = 1'b0;
        step(); check("ffff_wrap_q", q, 16'h0000); check("ffff_wrap_tc", 16'(tc), 16'h1);
        en = 1'b0;
        step(); check("hold_q", q, 16'h0000); check("hold_tc", 16'(tc), 16'h0);

        // scan of 1234 from a fresh reset
        rst = 1'b1; load = 1'b1; din = 16'h1234;
        #4 rst = 1'b0;
        step();
        check("scan_e1_an", 16'(an), 16'h000E);
        check("scan_e1_seg", 16'(seg), 16'h00C0);
        load = 1'b0;
        for (int n = 2; n <= 17; n++) begin
            step();
            check("scan_an", 16'(an), 16'(an_t[((n - 1) / 4) % 4]));
            check("scan_seg", 16'(seg), 16'(seg_t[((n - 1) / 4) % 4]));
        end
        check("scan_hold_q", q, 16'h1234);

        // leading-zero blanking of 0007
        rst = 1'b1; load = 1'b1; din = 16'h0007;
        #4 rst = 1'b0;
        step();
        check("lz7_e1_seg", 16'(seg_lz), 16'h00C0);
        load = 1'b0;
        for (int n = 2; n <= 16; n++) begin
            step();
            check("lz7_an", 16'(an_lz), 16'(an_t[(n - 1) / 4]));
            check("lz7_seg", 16'(seg_lz), 16'(lz_t[(n - 1) / 4]));
        end

        // all-zero count shows only digit 0
        rst = 1'b1;
        #4 rst = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            step();
            check("lz0_an", 16'(an_lz), 16'h000E);
            check("lz0_seg", 16'(seg_lz), 16'h00C0);
        end
        step();
        check("lz0_d1_an", 16'(an_lz), 16'h000D);
        check("lz0_d1_seg", 16'(seg_lz), 16'h00FF);

        // asynchronous reset mid-scan
        load = 1'b1; din = 16'h0456;
        step();
        load = 1'b0;
        step(); step();
        check("mid_q", q, 16'h0456);
        rst = 1'b1;
        #1;
        check("arst_q",   q, 16'h0000);
        check("arst_tc",  16'(tc), 16'h0);
        check("arst_seg", 16'(seg), 16'h00FF);
        check("arst_an",  16'(an), 16'h000F);
        #2 rst = 1'b0;
        step();
        check("arst_rel_an", 16'(an), 16'h000E);
        check("arst_rel_seg", 16'(seg), 16'h00C0);
        step(); step(); step();
        check("arst_e4_an", 16'(an), 16'h000E);
        step();
        check("arst_e5_an", 16'(an), 16'h000D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
